// File: rtl/spi_master_ctrl_if.sv
// SPI master control/serial bundle: host handshake plus the four-wire SPI pins.
// master modport is the controller's view, slave modport is the host/bench view.
interface spi_master_ctrl_if #(
    parameter int DATA_W = 4
);
    logic              start;
    logic [DATA_W-1:0] tx_data;
    logic              miso;
    logic              sclk;
    logic              mosi;
    logic              cs_n;
    logic [DATA_W-1:0] rx_data;
    logic              busy;
    logic              done;

    modport master (
        input  start, tx_data, miso,
        output sclk, mosi, cs_n, rx_data, busy, done
    );

    modport slave (
        output start, tx_data, miso,
        input  sclk, mosi, cs_n, rx_data, busy, done
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: one DATA_W-bit frame per accepted start, MSB first.
// Frame = LEAD half-period, 2*DATA_W SCLK transitions, TRAIL half-period.
// Every output comes straight from a flop.
module spi_master_ctrl #(
    parameter int DATA_W   = 4,
    parameter int HALF_DIV = 2
) (
    input  logic                  clk,
    input  logic                  clr,
    spi_master_ctrl_if.master     bus
);
    localparam int DIV_W = $clog2(HALF_DIV) + 1;
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

    state_t            state, state_nxt;
    logic [DIV_W-1:0]  div_cnt;
    logic [BIT_W-1:0]  bit_cnt;   // completed bits (falling edges) this frame
    logic [DATA_W-1:0] tx_sh, rx_sh, rx_q;
    logic              sclk_q, mosi_q, cs_n_q, busy_q, done_q;
    logic              tick, load, rise, fall, finish;

    // end of the current half-period
    assign tick = (div_cnt == DIV_LAST);

    // state register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= IDLE;
        else     state <= state_nxt;
    end

    // next state and per-edge action strobes
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        rise      = 1'b0;
        fall      = 1'b0;
        finish    = 1'b0;
        unique case (state)
            IDLE: if (bus.start) begin
                load      = 1'b1;
                state_nxt = LEAD;
            end
            LEAD: if (tick) state_nxt = XFER;
            XFER: if (tick) begin
                if (!sclk_q) begin
                    rise = 1'b1;
                end else begin
                    fall = 1'b1;
                    if (bit_cnt == BIT_LAST) state_nxt = TRAIL;
                end
            end
            TRAIL: if (tick) begin
                finish    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // divider, shift registers and registered outputs
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            tx_sh   <= '0;
            rx_sh   <= '0;
            rx_q    <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // divider sits at zero in IDLE so LEAD always gets a full half-period
            if (state == IDLE || tick) div_cnt <= '0;
            else                       div_cnt <= div_cnt + DIV_W'(1);
            if (load) begin
                tx_sh   <= bus.tx_data;
                mosi_q  <= bus.tx_data[DATA_W-1];
                rx_sh   <= '0;
                bit_cnt <= '0;
                cs_n_q  <= 1'b0;
                busy_q  <= 1'b1;
            end
            if (rise) begin
                sclk_q <= 1'b1;
                rx_sh  <= {rx_sh[DATA_W-2:0], bus.miso};
            end
            if (fall) begin
                sclk_q  <= 1'b0;
                tx_sh   <= {tx_sh[DATA_W-2:0], 1'b0};
                mosi_q  <= tx_sh[DATA_W-2];
                bit_cnt <= bit_cnt + BIT_W'(1);
            end
            if (finish) begin
                cs_n_q <= 1'b1;
                busy_q <= 1'b0;
                done_q <= 1'b1;
                rx_q   <= rx_sh;
            end
        end
    end

    assign bus.sclk    = sclk_q;
    assign bus.mosi    = mosi_q;
    assign bus.cs_n    = cs_n_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rx_data = rx_q;
endmodule

// File: doc/spi_master_ctrl.md
SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 Parameter DATA_W, default 4: frame width in bits; SHALL be >= 2.
REQ-002 Parameter HALF_DIV, default 2: CLK cycles per SCLK half-period; SHALL be >= 1.
REQ-003 CLK  in  1  system clock; all state SHALL change on its rising edge only.
REQ-004 CLR  in  1  reset; asynchronous, active-high, overrides all other inputs.
REQ-005 START  in  1  transfer request; sampled only in IDLE.
REQ-006 TX_DATA  in  DATA_W  parallel word to send, MSB first; captured on START acceptance.
REQ-007 MISO  in  1  serial data from slave.
REQ-008 SCLK  out  1  serial clock, mode 0 (idle low).
REQ-009 MOSI  out  1  serial data to slave.
REQ-010 CS_N  out  1  active-low slave select.
REQ-011 RX_DATA  out  DATA_W  last received word, MSB = first bit received.
REQ-012 BUSY  out  1  high while a frame is in progress.
REQ-013 DONE  out  1  one-CLK pulse at frame completion.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, LEAD, XFER, TRAIL.
REQ-015 IDLE: CS_N=1, SCLK=0, MOSI=0, BUSY=0; START=1 at a CLK edge SHALL latch TX_DATA and enter LEAD.
REQ-016 On entering LEAD: CS_N=0, BUSY=1, MOSI=TX_DATA[DATA_W-1], SCLK=0; LEAD SHALL last HALF_DIV cycles, then enter XFER.
REQ-017 XFER: SCLK SHALL toggle every HALF_DIV cycles, starting low→high, for exactly 2*DATA_W transitions, and SHALL end low.
REQ-018 At the CLK edge that drives SCLK 0→1, MISO SHALL be shifted into the RX shift register LSB (shift left).
REQ-019 At the CLK edge that drives SCLK 1→0, TX shift register SHALL shift left with 0 fill; MOSI SHALL present the new MSB (0 after the last bit).
REQ-020 After the final 1→0 transition, the FSM SHALL enter TRAIL: SCLK=0, CS_N=0, for HALF_DIV cycles.
REQ-021 On leaving TRAIL: return to IDLE; in that same edge CS_N=1, BUSY=0, DONE=1 for one cycle, RX_DATA loaded from RX shift register.
REQ-022 BUSY SHALL be high for exactly (2*DATA_W+2)*HALF_DIV cycles per frame (20 at defaults).
REQ-023 RX_DATA SHALL change only at DONE and hold otherwise.
REQ-024 START while BUSY=1 SHALL be ignored and not queued; TX_DATA changes while BUSY SHALL not affect the frame.
REQ-025 START high in the DONE cycle SHALL be accepted (IDLE), giving back-to-back frames with CS_N high for exactly one cycle.
REQ-026 Divider counter width SHALL be ceil(log2(HALF_DIV))+1 bits; bit counter SHALL count 0..DATA_W without wrap ambiguity.
REQ-027 All outputs SHALL be registered; no combinational path from input to output.

Reset
REQ-028 CLR=1 SHALL immediately force IDLE, CS_N=1, SCLK=0, MOSI=0, BUSY=0, DONE=0, RX_DATA=0, and clear all internal shift registers and counters.
REQ-029 CLR asserted mid-frame SHALL abort it with no DONE pulse, with RX_DATA=0; the first START after CLR release SHALL start a clean frame.

Verification
REQ-030 Loopback, defaults: MISO tied to MOSI, TX_DATA=4'b1011, START 1 cycle → CS_N low next cycle, 4 SCLK pulses of 4 cycles each, DONE 20 cycles after START edge, RX_DATA=4'b1011.
REQ-031 MISO held 1, TX_DATA=4'b0000 → MOSI stays 0 throughout, RX_DATA=4'b1111, exactly one DONE pulse.
REQ-032 START re-pulsed at cycles 3 and 10 of a frame → ignored; single frame, BUSY width 20 cycles.
REQ-033 START held high continuously with TX_DATA=4'b0110, loopback → back-to-back frames, each RX_DATA=4'b0110, CS_N high exactly 1 cycle between frames.
REQ-034 CLR pulsed after second SCLK rising edge → outputs at reset values asynchronously, no DONE; next START completes normally.
REQ-035 HALF_DIV=1, DATA_W=8, loopback TX_DATA=8'hA5 → SCLK toggles every cycle, BUSY 18 cycles, RX_DATA=8'hA5.
